// File: rtl/register_file_pkg.sv
// Shared constants and helpers for the register_file storage block:
// byte-lane geometry and address-width derivation.
package register_file_pkg;

  localparam int BYTE_W = 8;

  // Address width: at least one bit so a single-entry file still has a port.
  function automatic int calc_aw(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int lane_count(input int width);
    return width / BYTE_W;
  endfunction

endpackage

// File: rtl/register_file_word.sv
// One WIDTH-bit storage word with synchronous active-low clear and
// independent per-byte-lane write enables.
module register_word
  import register_file_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int LANES = WIDTH / BYTE_W
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [LANES-1:0] lane_we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Clear wins over any lane write presented on the same edge.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      q <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (lane_we[i]) begin
          q[i*BYTE_W +: BYTE_W] <= d[i*BYTE_W +: BYTE_W];
        end
      end
    end
  end

endmodule

// File: rtl/register_file.sv
// DEPTH x WIDTH register file: one synchronous byte-lane write port and two
// asynchronous read ports, each with an active-low tristate output enable.
module register_file
  import register_file_pkg::*;
#(
  parameter int  WIDTH    = 32,
  parameter int  DEPTH    = 8,
  parameter bit  ZERO_REG = 1'b0,
  parameter bit  BYPASS   = 1'b0,
  localparam int AW       = calc_aw(DEPTH)
) (
  input  logic                    CLK,
  input  logic                    N_RST,
  input  logic [WIDTH-1:0]        IN,
  input  logic [AW-1:0]           WADDR,
  input  logic                    N_WE,
  input  logic [WIDTH/BYTE_W-1:0] N_BE,
  input  logic [AW-1:0]           RADDR_A,
  input  logic [AW-1:0]           RADDR_B,
  input  logic                    N_OE_A,
  input  logic                    N_OE_B,
  output logic [WIDTH-1:0]        OUT_A,
  output logic [WIDTH-1:0]        OUT_B
);

  localparam int LANES = lane_count(WIDTH);

  logic [AW-1:0]    waddr_eff;
  logic [AW-1:0]    raddr_a_eff;
  logic [AW-1:0]    raddr_b_eff;
  logic             write_active;
  logic [WIDTH-1:0] words [DEPTH];
  logic             hit_a;
  logic             hit_b;
  logic [WIDTH-1:0] data_a;
  logic [WIDTH-1:0] data_b;

  // A single-entry file ignores every address bit, so all accesses land on word 0.
  generate
    if (DEPTH == 1) begin : g_single
      assign waddr_eff   = '0;
      assign raddr_a_eff = '0;
      assign raddr_b_eff = '0;
    end else begin : g_multi
      assign waddr_eff   = WADDR;
      assign raddr_a_eff = RADDR_A;
      assign raddr_b_eff = RADDR_B;
    end
  endgenerate

  assign write_active = N_RST && !N_WE;

  generate
    for (genvar g = 0; g < DEPTH; g++) begin : g_word
      if (ZERO_REG && (g == 0)) begin : g_zero
        assign words[g] = '0;
      end else begin : g_store
        logic [LANES-1:0] lane_we;
        assign lane_we = (write_active && (waddr_eff == AW'(g))) ? ~N_BE : '0;

        register_word #(
          .WIDTH (WIDTH)
        ) u_word (
          .clk     (CLK),
          .n_rst   (N_RST),
          .lane_we (lane_we),
          .d       (IN),
          .q       (words[g])
        );
      end
    end
  endgenerate

  // Forwarding substitutes only the lanes being written; the hardwired zero word never forwards.
  function automatic logic [WIDTH-1:0] lane_merge(
    input logic [WIDTH-1:0] stored,
    input logic [WIDTH-1:0] wdata,
    input logic [LANES-1:0] n_be,
    input logic             hit
  );
    logic [WIDTH-1:0] result;
    result = stored;
    for (int i = 0; i < LANES; i++) begin
      if (hit && !n_be[i]) begin
        result[i*BYTE_W +: BYTE_W] = wdata[i*BYTE_W +: BYTE_W];
      end
    end
    return result;
  endfunction

  always_comb begin
    hit_a = BYPASS && write_active && (raddr_a_eff == waddr_eff)
            && !(ZERO_REG && (raddr_a_eff == '0));
    hit_b = BYPASS && write_active && (raddr_b_eff == waddr_eff)
            && !(ZERO_REG && (raddr_b_eff == '0));
    data_a = lane_merge(words[raddr_a_eff], IN, N_BE, hit_a);
    data_b = lane_merge(words[raddr_b_eff], IN, N_BE, hit_b);
  end

  assign OUT_A = N_OE_A ? {WIDTH{1'bz}} : data_a;
  assign OUT_B = N_OE_B ? {WIDTH{1'bz}} : data_b;

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: a plain instance and a zero-register/bypass
// instance share all inputs and are checked against a behavioural model.
module tb_register_file;

  logic        clk;
  logic        n_rst;
  logic [31:0] in;
  logic [2:0]  waddr;
  logic        n_we;
  logic [3:0]  n_be;
  logic [2:0]  raddr_a;
  logic [2:0]  raddr_b;
  logic        n_oe_a;
  logic        n_oe_b;
  wire  [31:0] out_a0;
  wire  [31:0] out_b0;
  wire  [31:0] out_a1;
  wire  [31:0] out_b1;

  logic [31:0] exp_q[$];
  logic [31:0] exp;
  logic [31:0] mem0 [8];
  logic [31:0] mem1 [8];
  int          errors;
  int          checks;

  register_file #(
    .WIDTH (32), .DEPTH (8), .ZERO_REG (1'b0), .BYPASS (1'b0)
  ) dut0 (
    .CLK (clk), .N_RST (n_rst), .IN (in), .WADDR (waddr), .N_WE (n_we),
    .N_BE (n_be), .RADDR_A (raddr_a), .RADDR_B (raddr_b),
    .N_OE_A (n_oe_a), .N_OE_B (n_oe_b), .OUT_A (out_a0), .OUT_B (out_b0)
  );

  register_file #(
    .WIDTH (32), .DEPTH (8), .ZERO_REG (1'b1), .BYPASS (1'b1)
  ) dut1 (
    .CLK (clk), .N_RST (n_rst), .IN (in), .WADDR (waddr), .N_WE (n_we),
    .N_BE (n_be), .RADDR_A (raddr_a), .RADDR_B (raddr_b),
    .N_OE_A (n_oe_a), .N_OE_B (n_oe_b), .OUT_A (out_a1), .OUT_B (out_b1)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old,
                                              input logic [31:0] data,
                                              input logic [3:0]  nbe);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (!nbe[i]) r[i*8 +: 8] = data[i*8 +: 8];
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      mem0[i] = 32'h0;
      mem1[i] = 32'h0;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic pulse_reset();
    @(negedge clk);
    n_rst = 1'b0;
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    model_clear();
  endtask

  task automatic drive_write(input logic [2:0] a, input logic [31:0] d,
                             input logic [3:0] nbe);
    @(negedge clk);
    waddr = a;
    in    = d;
    n_be  = nbe;
    n_we  = 1'b0;
    @(posedge clk);
    #1;
    n_we = 1'b1;
    n_be = 4'hF;
    mem0[a] = merge_lanes(mem0[a], d, nbe);
    if (a != 3'd0) mem1[a] = merge_lanes(mem1[a], d, nbe);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    n_oe_a  = 1'b1;
    raddr_a = 3'd3;
    #1;
    exp_q.push_back({32{1'bz}});
    exp = exp_q.pop_front();
    checks++;
    if (out_a0 !== exp) begin
      errors++;
      $display("FAIL reset_oe_high got %h want %h", out_a0, exp);
    end
    n_oe_a = 1'b0;
    #1;
    exp_q.push_back(32'h0);
    exp = exp_q.pop_front();
    checks++;
    if (out_a0 !== exp) begin
      errors++;
      $display("FAIL reset_initial got %h want %h", out_a0, exp);
    end
    drive_write(3'd3, 32'hDEADBEEF, 4'h0);
    #1;
    exp_q.push_back(32'hDEADBEEF);
    exp = exp_q.pop_front();
    checks++;
    if (out_a0 !== exp) begin
      errors++;
      $display("FAIL reset_prewrite got %h want %h", out_a0, exp);
    end
    pulse_reset();
    #1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp = exp_q.pop_front();
    checks++;
    if (out_a0 !== exp) begin
      errors++;
      $display("FAIL reset_clear_dut0 got %h want %h", out_a0, exp);
    end
    exp = exp_q.pop_front();
    checks++;
    if (out_a1 !== exp) begin
      errors++;
      $display("FAIL reset_clear_dut1 got %h want %h", out_a1, exp);
    end
  endtask

  task automatic test_lane_write();
    drive_write(3'd2, 32'h11223344, 4'h0);
    drive_write(3'd2, 32'hAABBCCDD, 4'b1010);
    raddr_a = 3'd2;
    n_oe_a  = 1'b0;
    #1;
    exp_q.push_back(32'h11BB33DD);
    exp_q.push_back(32'h11BB33DD);
    exp = exp_q.pop_front();
    checks++;
    if (out_a0 !== exp) begin
      errors++;
      $display("FAIL lane_write_dut0 got %h want %h", out_a0, exp);
    end
    exp = exp_q.pop_front();
    checks++;
    if (out_a1 !== exp) begin
      errors++;
      $display("FAIL lane_write_dut1 got %h want %h", out_a1, exp);
    end
    drive_write(3'd2, 32'h00000000, 4'hF);
    #1;
    exp_q.push_back(32'h11BB33DD);
    exp = exp_q.pop_front();
    checks++;
    if (out_a0 !== exp) begin
      errors++;
      $display("FAIL lane_none_enabled got %h want %h", out_a0, exp);
    end
  endtask

  task automatic test_dual_read();
    drive_write(3'd1, 32'h5, 4'h0);
    drive_write(3'd4, 32'hA, 4'h0);
    raddr_a = 3'd1;
    raddr_b = 3'd4;
    n_oe_a  = 1'b0;
    n_oe_b  = 1'b1;
    #1;
    exp_q.push_back(32'h5);
    exp_q.push_back({32{1'bz}});
    exp = exp_q.pop_front();
    checks++;
    if (out_a0 !== exp) begin
      errors++;
      $display("FAIL dual_a_on got %h want %h", out_a0, exp);
    end
    exp = exp_q.pop_front();
    checks++;
    if (out_b0 !== exp) begin
      errors++;
      $display("FAIL dual_b_off got %h want %h", out_b0, exp);
    end
    n_oe_a = 1'b1;
    n_oe_b = 1'b0;
    #1;
    exp_q.push_back({32{1'bz}});
    exp_q.push_back(32'hA);
    exp = exp_q.pop_front();
    checks++;
    if (out_a0 !== exp) begin
      errors++;
      $display("FAIL dual_a_off got %h want %h", out_a0, exp);
    end
    exp = exp_q.pop_front();
    checks++;
    if (out_b0 !== exp) begin
      errors++;
      $display("FAIL dual_b_on got %h want %h", out_b0, exp);
    end
    // Both ports on the same word see identical data.
    n_oe_a  = 1'b0;
    raddr_a = 3'd4;
    #1;
    exp_q.push_back(32'hA);
    exp_q.push_back(32'hA);
    exp = exp_q.pop_front();
    checks++;
    if (out_a0 !== exp) begin
      errors++;
      $display("FAIL dual_same_a got %h want %h", out_a0, exp);
    end
    exp = exp_q.pop_front();
    checks++;
    if (out_b0 !== exp) begin
      errors++;
      $display("FAIL dual_same_b got %h want %h", out_b0, exp);
    end
  endtask

  task automatic test_collision();
    drive_write(3'd5, 32'h1, 4'h0);
    @(negedge clk);
    raddr_a = 3'd5;
    n_oe_a  = 1'b0;
    waddr   = 3'd5;
    in      = 32'h2;
    n_be    = 4'h0;
    n_we    = 1'b0;
    #1;
    exp_q.push_back(32'h1);
    exp_q.push_back(32'h2);
    exp = exp_q.pop_front();
    checks++;
    if (out_a0 !== exp) begin
      errors++;
      $display("FAIL collide_pre_nobypass got %h want %h", out_a0, exp);
    end
    exp = exp_q.pop_front();
    checks++;
    if (out_a1 !== exp) begin
      errors++;
      $display("FAIL collide_pre_bypass got %h want %h", out_a1, exp);
    end
    @(posedge clk);
    #1;
    n_we = 1'b1;
    n_be = 4'hF;
    mem0[5] = 32'h2;
    mem1[5] = 32'h2;
    exp_q.push_back(32'h2);
    exp = exp_q.pop_front();
    checks++;
    if (out_a0 !== exp) begin
      errors++;
      $display("FAIL collide_post got %h want %h", out_a0, exp);
    end
    // Partial-lane forward: disabled lanes keep the stored bytes.
    @(negedge clk);
    in   = 32'hAABBCCDD;
    n_be = 4'b1010;
    n_we = 1'b0;
    #1;
    exp_q.push_back(32'h00BB00DD);
    exp = exp_q.pop_front();
    checks++;
    if (out_a1 !== exp) begin
      errors++;
      $display("FAIL bypass_partial got %h want %h", out_a1, exp);
    end
    @(posedge clk);
    #1;
    n_we = 1'b1;
    n_be = 4'hF;
    mem0[5] = 32'h00BB00DD;
    mem1[5] = 32'h00BB00DD;
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    raddr_a = 3'd0;
    n_oe_a  = 1'b0;
    waddr   = 3'd0;
    in      = 32'hFFFFFFFF;
    n_be    = 4'h0;
    n_we    = 1'b0;
    #1;
    exp_q.push_back(32'h0);
    exp = exp_q.pop_front();
    checks++;
    if (out_a1 !== exp) begin
      errors++;
      $display("FAIL zero_bypass got %h want %h", out_a1, exp);
    end
    @(posedge clk);
    #1;
    n_we = 1'b1;
    n_be = 4'hF;
    mem0[0] = 32'hFFFFFFFF;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'hFFFFFFFF);
    exp = exp_q.pop_front();
    checks++;
    if (out_a1 !== exp) begin
      errors++;
      $display("FAIL zero_stored got %h want %h", out_a1, exp);
    end
    exp = exp_q.pop_front();
    checks++;
    if (out_a0 !== exp) begin
      errors++;
      $display("FAIL zero_plain_reg0 got %h want %h", out_a0, exp);
    end
  endtask

  task automatic test_reset_vs_write();
    drive_write(3'd6, 32'h99, 4'h0);
    @(negedge clk);
    raddr_a = 3'd6;
    n_oe_a  = 1'b0;
    n_rst   = 1'b0;
    waddr   = 3'd6;
    in      = 32'h7;
    n_be    = 4'h0;
    n_we    = 1'b0;
    #1;
    exp_q.push_back(32'h99);
    exp = exp_q.pop_front();
    checks++;
    if (out_a1 !== exp) begin
      errors++;
      $display("FAIL bypass_in_reset got %h want %h", out_a1, exp);
    end
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    n_we  = 1'b1;
    n_be  = 4'hF;
    model_clear();
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp = exp_q.pop_front();
    checks++;
    if (out_a0 !== exp) begin
      errors++;
      $display("FAIL reset_beats_write_dut0 got %h want %h", out_a0, exp);
    end
    exp = exp_q.pop_front();
    checks++;
    if (out_a1 !== exp) begin
      errors++;
      $display("FAIL reset_beats_write_dut1 got %h want %h", out_a1, exp);
    end
  endtask

  task automatic test_random();
    logic [2:0]  a;
    logic [31:0] d;
    logic [3:0]  nbe;
    n_oe_a = 1'b0;
    n_oe_b = 1'b0;
    for (int it = 0; it < 60; it++) begin
      a   = 3'($urandom_range(0, 7));
      d   = $urandom;
      nbe = 4'($urandom_range(0, 15));
      drive_write(a, d, nbe);
      raddr_a = 3'($urandom_range(0, 7));
      raddr_b = 3'($urandom_range(0, 7));
      exp_q.push_back(mem0[raddr_a]);
      exp_q.push_back(mem0[raddr_b]);
      exp_q.push_back(mem1[raddr_a]);
      exp_q.push_back(mem1[raddr_b]);
      #1;
      exp = exp_q.pop_front();
      checks++;
      if (out_a0 !== exp) begin
        errors++;
        $display("FAIL random_dut0_a addr %0d got %h want %h", raddr_a, out_a0, exp);
      end
      exp = exp_q.pop_front();
      checks++;
      if (out_b0 !== exp) begin
        errors++;
        $display("FAIL random_dut0_b addr %0d got %h want %h", raddr_b, out_b0, exp);
      end
      exp = exp_q.pop_front();
      checks++;
      if (out_a1 !== exp) begin
        errors++;
        $display("FAIL random_dut1_a addr %0d got %h want %h", raddr_a, out_a1, exp);
      end
      exp = exp_q.pop_front();
      checks++;
      if (out_b1 !== exp) begin
        errors++;
        $display("FAIL random_dut1_b addr %0d got %h want %h", raddr_b, out_b1, exp);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    errors  = 0;
    checks  = 0;
    n_rst   = 1'b0;
    in      = 32'h0;
    waddr   = 3'd0;
    n_we    = 1'b1;
    n_be    = 4'hF;
    raddr_a = 3'd0;
    raddr_b = 3'd0;
    n_oe_a  = 1'b1;
    n_oe_b  = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b1;

    test_reset();
    test_lane_write();
    test_dual_read();
    test_collision();
    test_zero_reg();
    test_reset_vs_write();
    test_random();

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left %0d want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
